serial_tx_frame_shifter: RTL

SERIAL_TX_FRAME_SHIFTER -- requirements
Module: serial_tx_frame_shifter

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_parity_gen.sv | 13 +
 rtl/serial_tx_frame_shifter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared serial package: frame FSM encoding and default sizes
package serial_pkg;

  localparam int SERIAL_DATA_W   = 8;
  localparam int SERIAL_STOP_MAX = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_EXTRA = 3'd3,
    ST_STOP  = 3'd4
  } serial_state_e;

endpackage

// File: rtl/serial_parity_gen.sv
// rtl/serial_parity_gen.sv - even parity over a payload word, shared by tx and rx
module serial_parity_gen
  import serial_pkg::*;
#(
  parameter int DATA_W = SERIAL_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/serial_tx_frame_shifter.sv
// rtl/serial_tx_frame_shifter.sv - serial transmit frame shifter (sync data-only or async framed)
module serial_tx_frame_shifter
  import serial_pkg::*;
#(
  parameter int DATA_W   = SERIAL_DATA_W,
  parameter int STOP_MAX = SERIAL_STOP_MAX
) (
  input  logic              serial_clock_i,
  input  logic              serial_reset_i_b,
  input  logic [DATA_W-1:0] serial_data_i,
  input  logic              serial_load_i,
  input  logic              serial_shift_i,
  input  logic              serial_mode_i,
  input  logic              serial_ninth_en_i,
  input  logic              serial_ninth_bit_i,
  input  logic              serial_parity_en_i,
  input  logic              serial_two_stop_i,
  output logic              serial_data_tx_o,
  output logic              serial_ready_o,
  output logic              serial_end_bit_o,
  output logic              serial_overrun_o
);

  localparam int CW          = $clog2(DATA_W + 1);
  localparam bit TWO_STOP_OK = (STOP_MAX > 1);

  serial_state_e     state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              mode_q, ninth_en_q, extra_q, two_stop_q;
  logic              tx_q, end_q, ovr_q;
  logic              tx_d, end_d;
  logic              parity;
  logic              load_ok;

  serial_parity_gen #(.DATA_W(DATA_W)) u_parity (
    .data_i   (serial_data_i),
    .parity_o (parity)
  );

  assign load_ok = serial_load_i && (state_q == ST_IDLE);

  // IDLE never looks at the tick, so a same-cycle load always wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    end_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (serial_load_i) begin
          shreg_d = serial_data_i;
          cnt_d   = '0;
          state_d = serial_mode_i ? ST_START : ST_DATA;
        end
      end
      ST_START: begin
        if (serial_shift_i) begin
          cnt_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (serial_shift_i) begin
          shreg_d = shreg_q >> 1;
          if (cnt_q == CW'(DATA_W - 1)) begin
            cnt_d = '0;
            if (!mode_q) begin
              state_d = ST_IDLE;
              end_d   = 1'b1;
            end else begin
              state_d = ninth_en_q ? ST_EXTRA : ST_STOP;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_EXTRA: begin
        if (serial_shift_i) begin
          cnt_d   = '0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (serial_shift_i) begin
          if (!two_stop_q || cnt_q == CW'(1)) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            end_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shreg_q[0];
      ST_EXTRA: tx_d = extra_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge serial_clock_i or negedge serial_reset_i_b) begin
    if (!serial_reset_i_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shreg_q    <= '0;
      mode_q     <= 1'b0;
      ninth_en_q <= 1'b0;
      extra_q    <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      end_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      end_q   <= end_d;
      ovr_q   <= serial_load_i && (state_q != ST_IDLE);
      if (load_ok) begin
        mode_q     <= serial_mode_i;
        ninth_en_q <= serial_ninth_en_i;
        extra_q    <= serial_parity_en_i ? parity : serial_ninth_bit_i;
        two_stop_q <= serial_two_stop_i && TWO_STOP_OK;
      end
    end
  end

  assign serial_data_tx_o = tx_q;
  assign serial_ready_o   = (state_q == ST_IDLE) && !end_q;
  assign serial_end_bit_o = end_q;
  assign serial_overrun_o = ovr_q;

endmodule
